// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types, response codes and master FSM state encodings.
package axi_lite_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [STRB_W-1:0] strb_t;
    typedef logic [1:0]        resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle: five independent channels, master and slave views.
interface axi_lite_if;
    import axi_lite_pkg::*;

    addr_t awaddr;
    logic  awvalid;
    logic  awready;

    data_t wdata;
    strb_t wstrb;
    logic  wvalid;
    logic  wready;

    resp_t bresp;
    logic  bvalid;
    logic  bready;

    addr_t araddr;
    logic  arvalid;
    logic  arready;

    data_t rdata;
    resp_t rresp;
    logic  rvalid;
    logic  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi_lite_watchdog.sv
// Cycle counter with synchronous clear; expired once enabled for limit cycles.
module axi_lite_watchdog #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // count_q holds the number of enabled cycles already completed, so the
    // limit-th cycle is the one that reports expiry.
    assign expired_o = (limit_i == '0) || (count_q >= limit_i - WIDTH'(1));

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !expired_o) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/axi_lite_master.sv
// AXI4-Lite master: each start pulse becomes one single-beat read or write.
// Optional response timeout is built when AXI_MST_TIMEOUT_EN is defined.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    input  logic                  start_write,
    input  logic                  start_read,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    axi_lite_if.master            bus,
    output logic                  wr_busy,
    output logic                  rd_busy,
    output logic                  wr_done,
    output logic                  rd_done,
    output resp_t                 wr_resp,
    output resp_t                 rd_resp,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  timeout_err
);

    wr_state_t wr_state_q, wr_state_d;
    addr_t     awaddr_q, awaddr_d;
    data_t     wdata_q, wdata_d;
    logic      awvalid_q, awvalid_d;
    logic      wvalid_q, wvalid_d;
    logic      bready_q, bready_d;
    logic      wr_done_q, wr_done_d;
    resp_t     wr_resp_q, wr_resp_d;
    logic      wr_timeout;
    logic      wr_expired;

    rd_state_t rd_state_q, rd_state_d;
    addr_t     araddr_q, araddr_d;
    logic      arvalid_q, arvalid_d;
    logic      rready_q, rready_d;
    logic      rd_done_q, rd_done_d;
    resp_t     rd_resp_q, rd_resp_d;
    data_t     rd_data_q, rd_data_d;
    logic      rd_timeout;
    logic      rd_expired;

    // Write channel
    always_comb begin
        wr_state_d = wr_state_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        wr_done_d  = 1'b0;
        wr_resp_d  = wr_resp_q;
        wr_timeout = 1'b0;

        unique case (wr_state_q)
            W_IDLE: begin
                if (start_write) begin
                    awaddr_d   = addr;
                    wdata_d    = data;
                    awvalid_d  = 1'b1;
                    wvalid_d   = 1'b1;
                    wr_state_d = W_ADDR_DATA;
                end
            end
            W_ADDR_DATA: begin
                // AW and W retire independently; B waits for both.
                if (awvalid_q && bus.awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && bus.wready) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    bready_d   = 1'b1;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bus.bvalid && bready_q) begin
                    wr_resp_d  = bus.bresp;
                    wr_done_d  = 1'b1;
                    bready_d   = 1'b0;
                    wr_state_d = W_IDLE;
                end else if (wr_expired) begin
                    wr_resp_d  = RESP_SLVERR;
                    wr_done_d  = 1'b1;
                    bready_d   = 1'b0;
                    wr_timeout = 1'b1;
                    wr_state_d = W_IDLE;
                end
            end
            default: begin
                wr_state_d = W_IDLE;
            end
        endcase
    end

    // Read channel
    always_comb begin
        rd_state_d = rd_state_q;
        araddr_d   = araddr_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        rd_done_d  = 1'b0;
        rd_resp_d  = rd_resp_q;
        rd_data_d  = rd_data_q;
        rd_timeout = 1'b0;

        unique case (rd_state_q)
            R_IDLE: begin
                if (start_read) begin
                    araddr_d   = addr;
                    arvalid_d  = 1'b1;
                    rd_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (arvalid_q && bus.arready) begin
                    arvalid_d  = 1'b0;
                    rready_d   = 1'b1;
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (bus.rvalid && rready_q) begin
                    rd_data_d  = bus.rdata;
                    rd_resp_d  = bus.rresp;
                    rd_done_d  = 1'b1;
                    rready_d   = 1'b0;
                    rd_state_d = R_IDLE;
                end else if (rd_expired) begin
                    rd_resp_d  = RESP_SLVERR;
                    rd_done_d  = 1'b1;
                    rready_d   = 1'b0;
                    rd_timeout = 1'b1;
                    rd_state_d = R_IDLE;
                end
            end
            default: begin
                rd_state_d = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            wr_state_q <= W_IDLE;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            wr_done_q  <= 1'b0;
            wr_resp_q  <= RESP_OKAY;
            rd_state_q <= R_IDLE;
            araddr_q   <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_resp_q  <= RESP_OKAY;
            rd_data_q  <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            wr_done_q  <= wr_done_d;
            wr_resp_q  <= wr_resp_d;
            rd_state_q <= rd_state_d;
            araddr_q   <= araddr_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            rd_done_q  <= rd_done_d;
            rd_resp_q  <= rd_resp_d;
            rd_data_q  <= rd_data_d;
        end
    end

`ifdef AXI_MST_TIMEOUT_EN
    localparam int unsigned WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT_CYCLES);

    logic timeout_err_q;

    // Held clear outside the response state, so each wait starts from zero.
    axi_lite_watchdog #(
        .WIDTH (WD_WIDTH)
    ) u_wr_watchdog (
        .clk_i     (aclk),
        .rst_ni    (areset_n),
        .clear_i   (wr_state_q != W_RESP),
        .enable_i  (wr_state_q == W_RESP),
        .limit_i   (WD_LIMIT),
        .expired_o (wr_expired)
    );

    axi_lite_watchdog #(
        .WIDTH (WD_WIDTH)
    ) u_rd_watchdog (
        .clk_i     (aclk),
        .rst_ni    (areset_n),
        .clear_i   (rd_state_q != R_DATA),
        .enable_i  (rd_state_q == R_DATA),
        .limit_i   (WD_LIMIT),
        .expired_o (rd_expired)
    );

    always_ff @(posedge aclk) begin
        if (!areset_n) begin
            timeout_err_q <= 1'b0;
        end else if (wr_timeout || rd_timeout) begin
            timeout_err_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_timeout;

    assign wr_expired     = 1'b0;
    assign rd_expired     = 1'b0;
    assign timeout_err    = 1'b0;
    assign unused_timeout = ^{TIMEOUT_CYCLES, wr_timeout, rd_timeout};
`endif

    assign bus.awaddr  = awaddr_q;
    assign bus.awvalid = awvalid_q;
    assign bus.wdata   = wdata_q;
    assign bus.wstrb   = '1;
    assign bus.wvalid  = wvalid_q;
    assign bus.bready  = bready_q;
    assign bus.araddr  = araddr_q;
    assign bus.arvalid = arvalid_q;
    assign bus.rready  = rready_q;

    assign wr_busy = (wr_state_q != W_IDLE);
    assign rd_busy = (rd_state_q != R_IDLE);
    assign wr_done = wr_done_q;
    assign rd_done = rd_done_q;
    assign wr_resp = wr_resp_q;
    assign rd_resp = rd_resp_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Self-checking bench for axi_lite_master: responsive slave model, vector
// table, completion scoreboard and hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    localparam int unsigned TO_CYCLES = 8;

    logic  aclk = 1'b0;
    logic  areset_n;
    logic  start_write;
    logic  start_read;
    addr_t addr;
    data_t data;
    logic  wr_busy, rd_busy, wr_done, rd_done, timeout_err;
    resp_t wr_resp, rd_resp;
    data_t rd_data;

    axi_lite_if bus ();

    axi_lite_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO_CYCLES)
    ) dut (
        .aclk        (aclk),
        .areset_n    (areset_n),
        .start_write (start_write),
        .start_read  (start_read),
        .addr        (addr),
        .data        (data),
        .bus         (bus),
        .wr_busy     (wr_busy),
        .rd_busy     (rd_busy),
        .wr_done     (wr_done),
        .rd_done     (rd_done),
        .wr_resp     (wr_resp),
        .rd_resp     (rd_resp),
        .rd_data     (rd_data),
        .timeout_err (timeout_err)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model configuration
    int    aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    bit    b_never = 1'b0;
    resp_t bresp_cfg = RESP_OKAY;
    resp_t rresp_cfg = RESP_OKAY;
    data_t rdata_cfg = '0;

    initial begin : slave
        int aw_wait, w_wait, b_wait, ar_wait, r_wait;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = RESP_OKAY;
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rresp = RESP_OKAY; bus.rdata = '0;
        forever begin
            @(posedge aclk);
            #1;
            if (!bus.awvalid) begin bus.awready = 1'b0; aw_wait = 0; end
            else if (aw_wait >= aw_delay) bus.awready = 1'b1;
            else begin bus.awready = 1'b0; aw_wait++; end

            if (!bus.wvalid) begin bus.wready = 1'b0; w_wait = 0; end
            else if (w_wait >= w_delay) bus.wready = 1'b1;
            else begin bus.wready = 1'b0; w_wait++; end

            if (!bus.bready || b_never) begin bus.bvalid = 1'b0; b_wait = 0; end
            else if (b_wait >= b_delay) begin bus.bvalid = 1'b1; bus.bresp = bresp_cfg; end
            else begin bus.bvalid = 1'b0; b_wait++; end

            if (!bus.arvalid) begin bus.arready = 1'b0; ar_wait = 0; end
            else if (ar_wait >= ar_delay) bus.arready = 1'b1;
            else begin bus.arready = 1'b0; ar_wait++; end

            if (!bus.rready) begin bus.rvalid = 1'b0; r_wait = 0; end
            else if (r_wait >= r_delay) begin
                bus.rvalid = 1'b1; bus.rresp = rresp_cfg; bus.rdata = rdata_cfg;
            end else begin bus.rvalid = 1'b0; r_wait++; end
        end
    end

    int aw_hs_count = 0;
    always @(posedge aclk) begin
        if (bus.awvalid && bus.awready) aw_hs_count <= aw_hs_count + 1;
    end

    // Scoreboard: expectations pushed at issue, popped on each done pulse
    typedef struct {
        resp_t resp;
        data_t rdata;
    } exp_t;
    exp_t wr_q[$];
    exp_t rd_q[$];

    task automatic push_wr(input resp_t r);
        exp_t e;
        e.resp = r; e.rdata = '0;
        wr_q.push_back(e);
    endtask

    task automatic push_rd(input resp_t r, input data_t d);
        exp_t e;
        e.resp = r; e.rdata = d;
        rd_q.push_back(e);
    endtask

    initial begin : scoreboard
        exp_t e;
        forever begin
            @(posedge aclk);
            #2;
            if (wr_done) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_wr_unexpected: wr_done=1, expected no completion");
                end else begin
                    e = wr_q.pop_front();
                    check("sb_wr_resp", wr_resp, e.resp);
                end
            end
            if (rd_done) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_rd_unexpected: rd_done=1, expected no completion");
                end else begin
                    e = rd_q.pop_front();
                    check("sb_rd_resp", rd_resp, e.resp);
                    check("sb_rd_data", rd_data, e.rdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // lat = edges after the reference edge until done is seen; -1 on timeout
    task automatic wait_done(input bit is_read, output int lat);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (is_read ? rd_done : wr_done) begin
                lat = k;
                return;
            end
        end
    endtask

    typedef struct {
        bit    is_read;
        addr_t a;
        data_t d;
        resp_t resp;
        data_t rdata;
        int    aw_d, w_d, b_d, ar_d, r_d;
        int    lat;
    } vec_t;

    vec_t vecs[7];

    initial begin : global_timeout
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int lat, wl, rl, hs0, done_cnt;
        vec_t v;

        vecs[0] = '{1'b0, 32'h10, 32'hDEADBEEF, RESP_OKAY, 32'h0, 0, 0, 0, 0, 0, 2};
        vecs[1] = '{1'b1, 32'h10, 32'h0, RESP_OKAY, 32'hDEADBEEF, 0, 0, 0, 0, 0, 2};
        vecs[2] = '{1'b0, 32'h24, 32'h12345678, RESP_EXOKAY, 32'h0, 3, 0, 0, 0, 0, 5};
        vecs[3] = '{1'b0, 32'h30, 32'h0BADF00D, RESP_DECERR, 32'h0, 0, 2, 1, 0, 0, 5};
        vecs[4] = '{1'b1, 32'h44, 32'h0, RESP_SLVERR, 32'hCAFEF00D, 0, 0, 0, 2, 3, 7};
        vecs[5] = '{1'b1, 32'hFFFFFFFC, 32'h0, RESP_OKAY, 32'hFFFFFFFF, 0, 0, 0, 0, 1, 3};
        vecs[6] = '{1'b0, 32'hFFFFFFFC, 32'h0, RESP_OKAY, 32'h0, 1, 1, 0, 0, 0, 3};

        areset_n = 1'b0; start_write = 1'b0; start_read = 1'b0; addr = '0; data = '0;
        repeat (3) tick();
        check("rst_awvalid", bus.awvalid, 0);
        check("rst_wvalid", bus.wvalid, 0);
        check("rst_bready", bus.bready, 0);
        check("rst_arvalid", bus.arvalid, 0);
        check("rst_rready", bus.rready, 0);
        check("rst_busy", {wr_busy, rd_busy, wr_done, rd_done}, 0);
        check("rst_resp", {wr_resp, rd_resp}, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_addr", {bus.awaddr, bus.araddr}, 0);
        check("rst_wdata", bus.wdata, 0);
        check("rst_timeout_err", timeout_err, 0);
        areset_n = 1'b1;
        tick();

        // Vector table; each start lands in the previous done cycle
        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            aw_delay = v.aw_d; w_delay = v.w_d; b_delay = v.b_d;
            ar_delay = v.ar_d; r_delay = v.r_d;
            bresp_cfg = v.resp; rresp_cfg = v.resp; rdata_cfg = v.rdata;
            addr = v.a; data = v.d;
            if (v.is_read) begin
                start_read = 1'b1;
                push_rd(v.resp, v.rdata);
            end else begin
                start_write = 1'b1;
                push_wr(v.resp);
            end
            tick();
            start_read = 1'b0; start_write = 1'b0;
            if (v.is_read) begin
                check("vec_arvalid", bus.arvalid, 1);
                check("vec_araddr", bus.araddr, v.a);
                check("vec_rd_busy", rd_busy, 1);
            end else begin
                check("vec_aw_w_valid", {bus.awvalid, bus.wvalid}, 2'b11);
                check("vec_awaddr", bus.awaddr, v.a);
                check("vec_wdata", bus.wdata, v.d);
                check("vec_wstrb", bus.wstrb, 4'hF);
            end
            wait_done(v.is_read, lat);
            check($sformatf("vec%0d_latency", i), lat, v.lat);
        end
        tick();

        // AW back-pressure of three cycles, W accepted immediately
        aw_delay = 3; w_delay = 0; b_delay = 0; bresp_cfg = RESP_OKAY;
        addr = 32'h80; data = 32'h55AA55AA; start_write = 1'b1;
        push_wr(RESP_OKAY);
        tick();
        start_write = 1'b0;
        check("bp_wvalid_n1", bus.wvalid, 1);
        tick();
        check("bp_wvalid_low_n2", bus.wvalid, 0);
        check("bp_awvalid_n2", bus.awvalid, 1);
        check("bp_bready_n2", bus.bready, 0);
        tick();
        check("bp_awvalid_n3", bus.awvalid, 1);
        tick();
        check("bp_awvalid_n4", bus.awvalid, 1);
        check("bp_awaddr_n4", bus.awaddr, 32'h80);
        tick();
        check("bp_awvalid_low_n5", bus.awvalid, 0);
        check("bp_bready_n5", bus.bready, 1);
        wait_done(1'b0, lat);
        check("bp_done_latency", lat, 1);
        aw_delay = 0;
        tick();

        // Simultaneous read and write share one address
        addr = 32'h200; data = 32'hA5A5A5A5;
        bresp_cfg = RESP_OKAY; rresp_cfg = RESP_EXOKAY; rdata_cfg = 32'h13572468;
        start_write = 1'b1; start_read = 1'b1;
        push_wr(RESP_OKAY);
        push_rd(RESP_EXOKAY, 32'h13572468);
        tick();
        start_write = 1'b0; start_read = 1'b0;
        check("sim_awaddr", bus.awaddr, 32'h200);
        check("sim_araddr", bus.araddr, 32'h200);
        wl = -1; rl = -1;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (wr_done) wl = k;
            if (rd_done) rl = k;
            if (wl > 0 && rl > 0) break;
        end
        check("sim_wr_latency", wl, 2);
        check("sim_rd_latency", rl, 2);
        tick();

        // Second start_write while busy is dropped
        aw_delay = 4;
        hs0 = aw_hs_count;
        addr = 32'h300; data = 32'h1; start_write = 1'b1;
        push_wr(RESP_OKAY);
        tick();
        addr = 32'h304; data = 32'h2;
        tick();
        start_write = 1'b0;
        check("busy_wr_busy", wr_busy, 1);
        check("busy_awaddr_held", bus.awaddr, 32'h300);
        check("busy_wdata_held", bus.wdata, 32'h1);
        wait_done(1'b0, lat);
        check("busy_latency", lat, 5);
        repeat (4) tick();
        check("busy_aw_handshakes", aw_hs_count - hs0, 1);
        check("busy_idle_after", wr_busy, 0);
        aw_delay = 0;

        // Reset while waiting in R_DATA abandons the read
        r_delay = 30; addr = 32'h400; start_read = 1'b1;
        tick();
        start_read = 1'b0;
        tick();
        check("rst_mid_rready_pre", bus.rready, 1);
        areset_n = 1'b0;
        tick();
        check("rst_mid_arvalid", bus.arvalid, 0);
        check("rst_mid_rready", bus.rready, 0);
        check("rst_mid_rd_busy", rd_busy, 0);
        check("rst_mid_rd_data", rd_data, 0);
        check("rst_mid_rd_resp", rd_resp, 0);
        areset_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (rd_done) done_cnt++;
        end
        check("rst_mid_no_done", done_cnt, 0);
        r_delay = 0;

        // Write response never arrives
        b_never = 1'b1;
        addr = 32'h500; data = 32'h77; start_write = 1'b1;
`ifdef AXI_MST_TIMEOUT_EN
        push_wr(RESP_SLVERR);
`endif
        tick();
        start_write = 1'b0;
        tick();
        check("to_bready", bus.bready, 1);
`ifdef AXI_MST_TIMEOUT_EN
        wait_done(1'b0, lat);
        check("to_latency", lat, TO_CYCLES);
        check("to_wr_resp", wr_resp, RESP_SLVERR);
        check("to_timeout_err", timeout_err, 1);
        check("to_bready_dropped", bus.bready, 0);
        tick();
        check("to_idle", wr_busy, 0);
`else
        repeat (3 * TO_CYCLES) tick();
        check("nto_still_busy", wr_busy, 1);
        check("nto_bready_held", bus.bready, 1);
        check("nto_timeout_err", timeout_err, 0);
        areset_n = 1'b0;
        tick();
        areset_n = 1'b1;
        tick();
        check("nto_idle_after_reset", wr_busy, 0);
`endif
        b_never = 1'b0;

        repeat (5) tick();
        check("sb_wr_drained", wr_q.size(), 0);
        check("sb_rd_drained", rd_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
